// File: rtl/regfile_write_arbiter_if.sv
// Bundle between WB/AUX requesters, the write arbiter and the register file write port.
// With REGFILE_ARB_BYPASS_EN defined, the read-forwarding signals are included.
interface regfile_write_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_reg;
   logic [DATA_W-1:0] wb_data;
   logic              wb_stall;
   logic              aux_valid;
   logic              aux_ready;
   logic [ADDR_W-1:0] aux_reg;
   logic [DATA_W-1:0] aux_data;
   logic [1:0]        aux_count;
   logic              rf_write_en;
   logic [ADDR_W-1:0] rf_write_reg;
   logic [DATA_W-1:0] rf_write_data;
`ifdef REGFILE_ARB_BYPASS_EN
   logic [ADDR_W-1:0] rd_reg_1;
   logic [ADDR_W-1:0] rd_reg_2;
   logic              rd_hit_1;
   logic              rd_hit_2;
   logic [DATA_W-1:0] rd_data_1;
   logic [DATA_W-1:0] rd_data_2;

   modport master (
      output wb_valid, wb_reg, wb_data, aux_valid, aux_reg, aux_data, rd_reg_1, rd_reg_2,
      input  wb_stall, aux_ready, aux_count, rf_write_en, rf_write_reg, rf_write_data,
      input  rd_hit_1, rd_hit_2, rd_data_1, rd_data_2
   );
   modport slave (
      input  wb_valid, wb_reg, wb_data, aux_valid, aux_reg, aux_data, rd_reg_1, rd_reg_2,
      output wb_stall, aux_ready, aux_count, rf_write_en, rf_write_reg, rf_write_data,
      output rd_hit_1, rd_hit_2, rd_data_1, rd_data_2
   );
`else
   modport master (
      output wb_valid, wb_reg, wb_data, aux_valid, aux_reg, aux_data,
      input  wb_stall, aux_ready, aux_count, rf_write_en, rf_write_reg, rf_write_data
   );
   modport slave (
      input  wb_valid, wb_reg, wb_data, aux_valid, aux_reg, aux_data,
      output wb_stall, aux_ready, aux_count, rf_write_en, rf_write_reg, rf_write_data
   );
`endif
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between WB (priority) and a 2-deep AUX FIFO with
// bounded starvation. Define REGFILE_ARB_BYPASS_EN to add read-forwarding of pending writes.
module regfile_write_arbiter #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 5,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic clk,
   input logic rst_n,
   regfile_write_arbiter_if.slave bus
);
   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   logic [ADDR_W-1:0] fifo_reg_q  [2];
   logic [DATA_W-1:0] fifo_data_q [2];
   logic              rd_ptr_q;
   logic [1:0]        count_q, count_d;
   logic [3:0]        starve_q, starve_d;
   logic              en_q;
   logic [ADDR_W-1:0] reg_q;
   logic [DATA_W-1:0] data_q;

   logic wb_eff, aux_rdy, push, head_valid, grant_aux, grant_wb, wr_ptr;

   always_comb begin
      wb_eff     = bus.wb_valid && (bus.wb_reg != '0);
      aux_rdy    = (count_q != 2'd2);
      push       = bus.aux_valid && aux_rdy && (bus.aux_reg != '0);
      head_valid = (count_q != 2'd0);
      grant_aux  = head_valid && (!wb_eff || (starve_q >= StarveMax));
      grant_wb   = wb_eff && !grant_aux;
      // Next free slot sits one past the head only when exactly one entry is held
      wr_ptr     = rd_ptr_q ^ count_q[0];
      count_d    = count_q + {1'b0, push} - {1'b0, grant_aux};
      starve_d   = starve_q;
      if (grant_aux || !head_valid) begin
         starve_d = 4'd0;
      end else if (grant_wb && (starve_q < StarveMax)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_reg_q[0]  <= '0;
         fifo_reg_q[1]  <= '0;
         fifo_data_q[0] <= '0;
         fifo_data_q[1] <= '0;
         rd_ptr_q       <= 1'b0;
         count_q        <= 2'd0;
         starve_q       <= 4'd0;
         en_q           <= 1'b0;
         reg_q          <= '0;
         data_q         <= '0;
      end else begin
         if (push) begin
            fifo_reg_q[wr_ptr]  <= bus.aux_reg;
            fifo_data_q[wr_ptr] <= bus.aux_data;
         end
         if (grant_aux) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q  <= count_d;
         starve_q <= starve_d;
         if (grant_wb) begin
            en_q   <= 1'b1;
            reg_q  <= bus.wb_reg;
            data_q <= bus.wb_data;
         end else if (grant_aux) begin
            en_q   <= 1'b1;
            reg_q  <= fifo_reg_q[rd_ptr_q];
            data_q <= fifo_data_q[rd_ptr_q];
         end else begin
            en_q <= 1'b0;
         end
      end
   end

   assign bus.wb_stall      = wb_eff && grant_aux;
   assign bus.aux_ready     = aux_rdy;
   assign bus.aux_count     = count_q;
   assign bus.rf_write_en   = en_q;
   assign bus.rf_write_reg  = reg_q;
   assign bus.rf_write_data = data_q;

`ifdef REGFILE_ARB_BYPASS_EN
   // Returns {hit, data}; newest FIFO entry beats head, head beats the in-flight write.
   function automatic logic [DATA_W:0] fwd(
      input logic [ADDR_W-1:0] a,
      input logic              tv, input logic [ADDR_W-1:0] tr, input logic [DATA_W-1:0] td,
      input logic              hv, input logic [ADDR_W-1:0] hr, input logic [DATA_W-1:0] hd,
      input logic              iv, input logic [ADDR_W-1:0] ir, input logic [DATA_W-1:0] id
   );
      logic [DATA_W:0] r;
      r = '0;
      if (a != '0) begin
         if (tv && (tr == a))      r = {1'b1, td};
         else if (hv && (hr == a)) r = {1'b1, hd};
         else if (iv && (ir == a)) r = {1'b1, id};
      end
      return r;
   endfunction

   logic [DATA_W:0] fwd_1, fwd_2;
   logic            tail_valid;

   always_comb begin
      tail_valid = (count_q == 2'd2);
      fwd_1 = fwd(bus.rd_reg_1,
                  tail_valid, fifo_reg_q[~rd_ptr_q], fifo_data_q[~rd_ptr_q],
                  head_valid, fifo_reg_q[rd_ptr_q], fifo_data_q[rd_ptr_q],
                  en_q, reg_q, data_q);
      fwd_2 = fwd(bus.rd_reg_2,
                  tail_valid, fifo_reg_q[~rd_ptr_q], fifo_data_q[~rd_ptr_q],
                  head_valid, fifo_reg_q[rd_ptr_q], fifo_data_q[rd_ptr_q],
                  en_q, reg_q, data_q);
   end

   assign bus.rd_hit_1  = fwd_1[DATA_W];
   assign bus.rd_data_1 = fwd_1[DATA_W-1:0];
   assign bus.rd_hit_2  = fwd_2[DATA_W];
   assign bus.rd_data_2 = fwd_2[DATA_W-1:0];
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected register-file writes are queued as
// stimulus is issued; a monitor pops and compares on every rf_write_en cycle.
module tb_regfile_write_arbiter;
   logic clk;
   logic rst_n;

   regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regfile_write_arbiter #(
      .DATA_W      (32),
      .ADDR_W      (5),
      .STARVE_LIMIT(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  vectors    = 0;
   int  miscompares = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
      wr_t e;
      e.r = r;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic drive_idle();
      bus.wb_valid  = 1'b0;
      bus.wb_reg    = '0;
      bus.wb_data   = '0;
      bus.aux_valid = 1'b0;
      bus.aux_reg   = '0;
      bus.aux_data  = '0;
   endtask

   // Monitor: every write seen on the register file port must be the next expected one
   always @(negedge clk) begin
      if (rst_n && bus.rf_write_en) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected no write",
                     bus.rf_write_reg, bus.rf_write_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (bus.rf_write_reg !== e.r || bus.rf_write_data !== e.d) begin
               miscompares++;
               $display("FAIL write_order: got reg %0d data 0x%0h expected reg %0d data 0x%0h",
                        bus.rf_write_reg, bus.rf_write_data, e.r, e.d);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      drive_idle();
`ifdef REGFILE_ARB_BYPASS_EN
      bus.rd_reg_1 = '0;
      bus.rd_reg_2 = '0;
`endif
      #3;
      chk("reset_en", 32'(bus.rf_write_en), 32'd0);
      chk("reset_reg", 32'(bus.rf_write_reg), 32'd0);
      chk("reset_data", bus.rf_write_data, 32'd0);
      chk("reset_count", 32'(bus.aux_count), 32'd0);
      chk("reset_stall", 32'(bus.wb_stall), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("reset_ready", 32'(bus.aux_ready), 32'd1);

      // WB only
      step();
      bus.wb_valid = 1'b1; bus.wb_reg = 5'd3; bus.wb_data = 32'd55;
      expect_wr(5'd3, 32'd55);
      @(negedge clk);
      chk("wb_only_stall", 32'(bus.wb_stall), 32'd0);
      step();
      drive_idle();
      repeat (2) step();

      // Zero register on both sources: nothing written, nothing queued
      bus.wb_valid = 1'b1; bus.wb_reg = 5'd0; bus.wb_data = 32'd123;
      @(negedge clk);
      chk("zero_wb_stall", 32'(bus.wb_stall), 32'd0);
      step();
      drive_idle();
      bus.aux_valid = 1'b1; bus.aux_reg = 5'd0; bus.aux_data = 32'd9;
      @(negedge clk);
      chk("zero_aux_ready", 32'(bus.aux_ready), 32'd1);
      step();
      drive_idle();
      @(negedge clk);
      chk("zero_count", 32'(bus.aux_count), 32'd0);
      chk("zero_no_write", 32'(bus.rf_write_en), 32'd0);
      step();

      // FIFO full while WB busy, then drain in order
      bus.wb_valid = 1'b1; bus.wb_reg = 5'd10; bus.wb_data = 32'd100;
      bus.aux_valid = 1'b1; bus.aux_reg = 5'd5; bus.aux_data = 32'hA;
      expect_wr(5'd10, 32'd100);
      step();
      bus.wb_reg = 5'd11; bus.wb_data = 32'd101;
      bus.aux_reg = 5'd6; bus.aux_data = 32'hB;
      expect_wr(5'd11, 32'd101);
      @(negedge clk);
      chk("full_stall_b", 32'(bus.wb_stall), 32'd0);
      step();
      drive_idle();
      expect_wr(5'd5, 32'hA);
      expect_wr(5'd6, 32'hB);
      @(negedge clk);
      chk("full_count", 32'(bus.aux_count), 32'd2);
      chk("full_ready", 32'(bus.aux_ready), 32'd0);
      repeat (3) step();
      @(negedge clk);
      chk("drained_count", 32'(bus.aux_count), 32'd0);
      step();

      // Starvation: AUX queued under continuous WB, preempts on the 5th cycle
      for (int i = 0; i < 5; i++) expect_wr(5'd12, 32'(200 + i));
      expect_wr(5'd7, 32'h77);
      expect_wr(5'd12, 32'd205);
      for (int i = 0; i < 7; i++) begin
         bus.wb_valid  = 1'b1;
         bus.wb_reg    = 5'd12;
         bus.wb_data   = 32'(200 + ((i < 5) ? i : 5));
         bus.aux_valid = (i == 0);
         bus.aux_reg   = 5'd7;
         bus.aux_data  = 32'h77;
         @(negedge clk);
         chk($sformatf("starve_stall_%0d", i), 32'(bus.wb_stall), (i == 5) ? 32'd1 : 32'd0);
         step();
      end
      drive_idle();
      repeat (3) step();

`ifdef REGFILE_ARB_BYPASS_EN
      // Forwarding: newest matching FIFO entry wins, r0 never hits
      bus.rd_reg_1 = 5'd9;
      bus.rd_reg_2 = 5'd0;
      expect_wr(5'd12, 32'd400);
      expect_wr(5'd12, 32'd401);
      expect_wr(5'd12, 32'd402);
      expect_wr(5'd9, 32'h99);
      expect_wr(5'd9, 32'hAA);
      bus.wb_valid = 1'b1; bus.wb_reg = 5'd12; bus.wb_data = 32'd400;
      bus.aux_valid = 1'b1; bus.aux_reg = 5'd9; bus.aux_data = 32'h99;
      step();
      bus.wb_data = 32'd401;
      bus.aux_data = 32'hAA;
      @(negedge clk);
      chk("byp_hit_1", 32'(bus.rd_hit_1), 32'd1);
      chk("byp_data_head", bus.rd_data_1, 32'h99);
      chk("byp_hit_2_r0", 32'(bus.rd_hit_2), 32'd0);
      step();
      bus.aux_valid = 1'b0;
      bus.wb_data = 32'd402;
      @(negedge clk);
      chk("byp_data_newest", bus.rd_data_1, 32'hAA);
      step();
      drive_idle();
      repeat (4) step();
`endif

      // Reset mid-stream with two pending AUX entries: they must be lost
      bus.wb_valid = 1'b1; bus.wb_reg = 5'd13; bus.wb_data = 32'd300;
      bus.aux_valid = 1'b1; bus.aux_reg = 5'd14; bus.aux_data = 32'h1;
      expect_wr(5'd13, 32'd300);
      step();
      bus.wb_data = 32'd301;
      bus.aux_reg = 5'd15; bus.aux_data = 32'h2;
      expect_wr(5'd13, 32'd301);
      step();
      drive_idle();
      @(negedge clk);
      chk("pre_reset_count", 32'(bus.aux_count), 32'd2);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_reset_en", 32'(bus.rf_write_en), 32'd0);
      chk("mid_reset_reg", 32'(bus.rf_write_reg), 32'd0);
      chk("mid_reset_data", bus.rf_write_data, 32'd0);
      chk("mid_reset_count", 32'(bus.aux_count), 32'd0);
      chk("mid_reset_stall", 32'(bus.wb_stall), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("post_reset_ready", 32'(bus.aux_ready), 32'd1);
      repeat (5) step();
      @(negedge clk);
      chk("post_reset_count", 32'(bus.aux_count), 32'd0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
